// File: rtl/sys_array_ctrl_if.sv
// Control/status bundle between the systolic-array sequencer and its buffers.
// The master side drives the pass request; the slave side (the sequencer) drives everything else.
interface sys_array_ctrl_if #(
    parameter int ARRAY_H = 4,
    parameter int ARRAY_W = 4,
    parameter int M_WIDTH = 8
);
    localparam int AW = $clog2(ARRAY_H);

    logic               start;
    logic [M_WIDTH-1:0] n_vectors;
    logic               keep_weights;
    logic               busy;
    logic               done;
    logic               param_load;
    logic [AW-1:0]      w_addr;
    logic               in_rd_en;
    logic [M_WIDTH-1:0] in_addr;
    logic [ARRAY_H-1:0] in_lane_valid;
    logic [ARRAY_W-1:0] out_col_valid;
    logic [M_WIDTH-1:0] out_addr;

    modport master (
        output start, n_vectors, keep_weights,
        input  busy, done, param_load, w_addr, in_rd_en, in_addr,
               in_lane_valid, out_col_valid, out_addr
    );

    modport slave (
        input  start, n_vectors, keep_weights,
        output busy, done, param_load, w_addr, in_rd_en, in_addr,
               in_lane_valid, out_col_valid, out_addr
    );
endinterface

// File: rtl/sys_array_ctrl.sv
// Pass sequencer for a weight-stationary ARRAY_H x ARRAY_W systolic array:
// weight load, skewed input feed and output drain. No datapath lives here.
module sys_array_ctrl #(
    parameter int ARRAY_H = 4,
    parameter int ARRAY_W = 4,
    parameter int M_WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    sys_array_ctrl_if.slave bus
);
    localparam int AW = $clog2(ARRAY_H);
    // Wide enough for the last stream index, M_max + ARRAY_H + ARRAY_W - 2.
    localparam int TW = M_WIDTH + $clog2(ARRAY_H + ARRAY_W) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t             state;
    logic [AW-1:0]      lc;
    logic [TW-1:0]      t;
    logic [M_WIDTH-1:0] m_q;

    logic [TW-1:0] m_ext;
    logic [TW-1:0] t_last;

    assign m_ext  = TW'(m_q);
    assign t_last = m_ext + TW'(ARRAY_H + ARRAY_W - 2);

    // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            lc    <= '0;
            t     <= '0;
            m_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_q <= bus.n_vectors;
                        lc  <= '0;
                        t   <= '0;
                        if (bus.n_vectors == '0)  state <= DONE;
                        else if (bus.keep_weights) state <= STREAM;
                        else                       state <= LOAD;
                    end
                end
                LOAD: begin
                    if (lc == AW'(ARRAY_H - 1)) begin
                        lc    <= '0;
                        t     <= '0;
                        state <= STREAM;
                    end else begin
                        lc <= lc + AW'(1);
                    end
                end
                STREAM: begin
                    if (t == t_last) begin
                        t     <= '0;
                        state <= DONE;
                    end else begin
                        t <= t + TW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs depend only on state, lc, t and m_q, so no input reaches an output combinationally.
    // NOTE: every output gets a default first so no branch can infer a latch.
    always_comb begin
        bus.busy          = (state != IDLE);
        bus.done          = (state == DONE);
        bus.param_load    = 1'b0;
        bus.w_addr        = '0;
        bus.in_rd_en      = 1'b0;
        bus.in_addr       = '0;
        bus.in_lane_valid = '0;
        bus.out_col_valid = '0;
        bus.out_addr      = '0;

        if (state == LOAD) begin
            // Bottom row's weight goes in first so it has shifted furthest when loading ends.
            bus.param_load = 1'b1;
            bus.w_addr     = AW'(ARRAY_H - 1) - lc;
        end

        if (state == STREAM) begin
            if (t < m_ext) begin
                bus.in_rd_en = 1'b1;
                bus.in_addr  = t[M_WIDTH-1:0];
            end
            for (int r = 0; r < ARRAY_H; r++) begin
                bus.in_lane_valid[r] = (t >= TW'(r)) && (t < TW'(r) + m_ext);
            end
            // Column c's bottom-row result lags its first input by ARRAY_H + c hops.
            for (int c = 0; c < ARRAY_W; c++) begin
                bus.out_col_valid[c] = (t >= TW'(ARRAY_H + c)) && (t < TW'(ARRAY_H + c) + m_ext);
            end
            if (bus.out_col_valid[0]) begin
                bus.out_addr = M_WIDTH'(t - TW'(ARRAY_H));
            end
        end
    end
endmodule

// File: tb/tb_sys_array_ctrl.sv
// Self-checking bench for sys_array_ctrl: table of pass scenarios checked cycle by cycle
// through a scoreboard, plus hand-written restart and reset sequences.
module tb_sys_array_ctrl;
    localparam int H  = 4;
    localparam int W  = 4;
    localparam int MW = 8;
    localparam int AW = $clog2(H);

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          param_load;
        logic [AW-1:0] w_addr;
        logic          in_rd_en;
        logic [MW-1:0] in_addr;
        logic [H-1:0]  lane;
        logic [W-1:0]  col;
        logic [MW-1:0] out_addr;
    } outs_t;

    typedef struct {
        int          m;
        bit          keep;
        int          exp_done;
        int          exp_loads;
        int          exp_reads;
        logic [63:0] start_mask;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    sys_array_ctrl_if #(.ARRAY_H(H), .ARRAY_W(W), .M_WIDTH(MW)) bus();

    sys_array_ctrl #(.ARRAY_H(H), .ARRAY_W(W), .M_WIDTH(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    outs_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic outs_t sample();
        outs_t o;
        o.busy       = bus.busy;
        o.done       = bus.done;
        o.param_load = bus.param_load;
        o.w_addr     = bus.w_addr;
        o.in_rd_en   = bus.in_rd_en;
        o.in_addr    = bus.in_addr;
        o.lane       = bus.in_lane_valid;
        o.col        = bus.out_col_valid;
        o.out_addr   = bus.out_addr;
        return o;
    endfunction

    // Expected outputs in cycle k of a pass whose start was accepted in cycle 0.
    function automatic outs_t model(input int k, input int m, input bit keep);
        outs_t o;
        int lo, total, s;
        o = '0;
        if (m == 0) begin
            if (k == 1) begin
                o.busy = 1'b1;
                o.done = 1'b1;
            end
            return o;
        end
        lo    = keep ? 0 : H;
        total = m + lo + H + W;
        if (k >= 1 && k <= total) o.busy = 1'b1;
        if (k == total)           o.done = 1'b1;
        if (!keep && k >= 1 && k <= H) begin
            o.param_load = 1'b1;
            o.w_addr     = AW'(H - k);
        end
        s = k - 1 - lo;
        if (k < total && s >= 0) begin
            if (s < m) begin
                o.in_rd_en = 1'b1;
                o.in_addr  = MW'(s);
            end
            for (int r = 0; r < H; r++) if (s >= r && s < r + m) o.lane[r] = 1'b1;
            for (int c = 0; c < W; c++) if (s >= H + c && s < H + c + m) o.col[c] = 1'b1;
            if (o.col[0]) o.out_addr = MW'(s - H);
        end
        return o;
    endfunction

    task automatic run_pass(input string tag, input int m, input bit keep, input logic [63:0] mask,
                            output int done_cyc, output int loads, output int reads);
        int    total;
        outs_t exp, act;
        done_cyc = -1;
        loads    = 0;
        reads    = 0;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.n_vectors    = MW'(m);
        bus.keep_weights = keep;
        total = (m == 0) ? 1 : m + (keep ? 0 : H) + H + W;
        for (int k = 1; k <= total + 2; k++) sb.push_back(model(k, m, keep));
        @(negedge clk);
        // Scramble the pass parameters: they must only matter in the accept cycle.
        bus.n_vectors    = ~MW'(m);
        bus.keep_weights = !keep;
        for (int k = 1; k <= total + 2; k++) begin
            act = sample();
            exp = sb.pop_front();
            check($sformatf("%s_cyc%0d", tag, k), 64'(act), 64'(exp));
            if (act.done && done_cyc < 0) done_cyc = k;
            if (act.param_load) loads++;
            if (act.in_rd_en)   reads++;
            bus.start = (k < 64) ? mask[k] : 1'b0;
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        int done_cyc, loads, reads, done_at, done_seen;

        vecs[0] = '{m: 3,   keep: 1'b0, exp_done: 15,  exp_loads: 4, exp_reads: 3,   start_mask: 64'h0};
        vecs[1] = '{m: 2,   keep: 1'b1, exp_done: 10,  exp_loads: 0, exp_reads: 2,   start_mask: 64'h0};
        vecs[2] = '{m: 0,   keep: 1'b0, exp_done: 1,   exp_loads: 0, exp_reads: 0,   start_mask: 64'h0};
        vecs[3] = '{m: 0,   keep: 1'b1, exp_done: 1,   exp_loads: 0, exp_reads: 0,   start_mask: 64'h0};
        vecs[4] = '{m: 1,   keep: 1'b0, exp_done: 13,  exp_loads: 4, exp_reads: 1,   start_mask: 64'h0};
        vecs[5] = '{m: 5,   keep: 1'b1, exp_done: 13,  exp_loads: 0, exp_reads: 5,   start_mask: 64'h0};
        vecs[6] = '{m: 3,   keep: 1'b0, exp_done: 15,  exp_loads: 4, exp_reads: 3,   start_mask: 64'h208};
        vecs[7] = '{m: 255, keep: 1'b1, exp_done: 263, exp_loads: 0, exp_reads: 255, start_mask: 64'h0};
        vecs[8] = '{m: 255, keep: 1'b0, exp_done: 267, exp_loads: 4, exp_reads: 255, start_mask: 64'h0};
        vecs[9] = '{m: 7,   keep: 1'b0, exp_done: 19,  exp_loads: 4, exp_reads: 7,   start_mask: 64'h0};

        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.n_vectors    = '0;
        bus.keep_weights = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(sample()), 64'(0));
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_pass($sformatf("v%0d", i), vecs[i].m, vecs[i].keep, vecs[i].start_mask,
                     done_cyc, loads, reads);
            check($sformatf("v%0d_done_cycle", i), 64'(done_cyc), 64'(vecs[i].exp_done));
            check($sformatf("v%0d_loads", i), 64'(loads), 64'(vecs[i].exp_loads));
            check($sformatf("v%0d_reads", i), 64'(reads), 64'(vecs[i].exp_reads));
        end

        // start held high: IDLE in cycle 16, second LOAD from cycle 17.
        @(negedge clk);
        bus.start        = 1'b1;
        bus.n_vectors    = MW'(3);
        bus.keep_weights = 1'b0;
        done_at = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                done_at = k;
                break;
            end
        end
        check("hold_done_cycle", 64'(done_at), 64'(15));
        @(negedge clk);
        check("hold_idle_busy", 64'(bus.busy), 64'(0));
        @(negedge clk);
        check("hold_reload", 64'({bus.param_load, bus.w_addr}), 64'({1'b1, AW'(H - 1)}));
        bus.start = 1'b0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset in cycle 7 of a pass abandons it without a done pulse.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.n_vectors = MW'(3);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_pre_stream", 64'({bus.in_rd_en, bus.in_addr}), 64'({1'b1, MW'(2)}));
        reset = 1'b1;
        @(negedge clk);
        check("rst_outputs_zero", 64'(sample()), 64'(0));
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        check("rst_no_done", 64'(done_seen), 64'(0));
        run_pass("after_rst", 3, 1'b0, 64'h0, done_cyc, loads, reads);
        check("after_rst_done_cycle", 64'(done_cyc), 64'(15));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
